// File: rtl/switch_conditioner.sv
// Synchronizes and debounces raw switches; emits one-cycle rise/fall
// pulses and a changed flag. SWITCH_TOGGLE_EN adds push-on/push-off bits.
//
// Ports:
//   clk_2       : system clock
//   reset_n     : async active-low reset
//   swi_raw     : raw asynchronous switch levels
//   swi_db      : debounced levels
//   swi_rise    : one-cycle pulse on debounced 0->1
//   swi_fall    : one-cycle pulse on debounced 1->0
//   swi_changed : OR of rise/fall, aligned with them
//   swi_toggle  : per-bit toggle latch (0 unless SWITCH_TOGGLE_EN)
module switch_conditioner #(
  parameter int NBITS           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic [NBITS-1:0] swi_raw,
  output logic [NBITS-1:0] swi_db,
  output logic [NBITS-1:0] swi_rise,
  output logic [NBITS-1:0] swi_fall,
  output logic             swi_changed,
  output logic [NBITS-1:0] swi_toggle
);

  typedef enum logic {
    STABLE,
    PENDING
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NBITS-1:0] sync1_q, sync2_q;
  logic [NBITS-1:0] db_q, db_d;
  logic [NBITS-1:0] rise_q, rise_d;
  logic [NBITS-1:0] fall_q, fall_d;
  logic             chg_q, chg_d;
  state_e           st_q  [NBITS];
  state_e           st_d  [NBITS];
  logic [CNT_W-1:0] cnt_q [NBITS];
  logic [CNT_W-1:0] cnt_d [NBITS];

  // The count includes the current mismatching cycle, so a change is
  // accepted on the DEBOUNCE_CYCLES-th consecutive mismatch seen.
  always_comb begin
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < NBITS; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      unique case (st_q[i])
        STABLE: begin
          if (sync2_q[i] != db_q[i]) begin
            if (CNT_ONE == CNT_MAX) begin
              db_d[i]   = sync2_q[i];
              rise_d[i] = sync2_q[i];
              fall_d[i] = ~sync2_q[i];
            end else begin
              st_d[i]  = PENDING;
              cnt_d[i] = CNT_ONE;
            end
          end
        end
        PENDING: begin
          if (sync2_q[i] == db_q[i]) begin
            st_d[i]  = STABLE;
            cnt_d[i] = '0;
          end else if (cnt_q[i] + CNT_ONE == CNT_MAX) begin
            st_d[i]   = STABLE;
            cnt_d[i]  = '0;
            db_d[i]   = sync2_q[i];
            rise_d[i] = sync2_q[i];
            fall_d[i] = ~sync2_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
      endcase
    end
    chg_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      chg_q   <= 1'b0;
      for (int i = 0; i < NBITS; i++) begin
        st_q[i]  <= STABLE;
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= swi_raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      chg_q   <= chg_d;
      for (int i = 0; i < NBITS; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign swi_db      = db_q;
  assign swi_rise    = rise_q;
  assign swi_fall    = fall_q;
  assign swi_changed = chg_q;

`ifdef SWITCH_TOGGLE_EN
  logic [NBITS-1:0] toggle_q, toggle_d;

  // Flips on the same edge that raises the rise pulse.
  always_comb begin
    toggle_d = toggle_q ^ rise_d;
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_d;
    end
  end

  assign swi_toggle = toggle_q;
`else
  assign swi_toggle = '0;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: run-length reference model checked
// every cycle, plus literal checks of latency, pulses and reset.
module tb_switch_conditioner;

  localparam int NB = 8;
  localparam int DC = 4;

  logic          clk_2 = 1'b0;
  logic          reset_n = 1'b1;
  logic [NB-1:0] swi_raw = '0;
  logic [NB-1:0] swi_db, swi_rise, swi_fall, swi_toggle;
  logic          swi_changed;

  switch_conditioner #(
    .NBITS(NB),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk_2(clk_2),
    .reset_n(reset_n),
    .swi_raw(swi_raw),
    .swi_db(swi_db),
    .swi_rise(swi_rise),
    .swi_fall(swi_fall),
    .swi_changed(swi_changed),
    .swi_toggle(swi_toggle)
  );

  always #5 clk_2 = ~clk_2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm,
                       input logic [NB-1:0] act,
                       input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: raw is seen by the debouncer two edges after sampling;
  // a bit flips once it has disagreed with the debounced value on DC
  // consecutive edges.
  logic [NB-1:0] m_s1, m_s2, m_seen;
  logic [NB-1:0] m_db, m_rise, m_fall, m_tog;
  logic          m_chg;
  int            run [NB];

  initial begin
    forever begin
      @(posedge clk_2 or negedge reset_n);
      if (!reset_n) begin
        m_s1 = '0; m_s2 = '0; m_db = '0;
        m_rise = '0; m_fall = '0;
        m_tog = '0; m_chg = 1'b0;
        for (int i = 0; i < NB; i++) run[i] = 0;
      end else begin
        m_seen = m_s2;
        m_s2 = m_s1;
        m_s1 = swi_raw;
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < NB; i++) begin
          if (m_seen[i] != m_db[i]) begin
            run[i]++;
            if (run[i] == DC) begin
              m_db[i] = m_seen[i];
              if (m_seen[i]) m_rise[i] = 1'b1;
              else m_fall[i] = 1'b1;
              run[i] = 0;
            end
          end else begin
            run[i] = 0;
          end
        end
        m_chg = |(m_rise | m_fall);
`ifdef SWITCH_TOGGLE_EN
        m_tog = m_tog ^ m_rise;
`endif
      end
    end
  end

  always @(negedge clk_2) begin
    if (chk_en && reset_n) begin
      check("m_db", swi_db, m_db);
      check("m_rise", swi_rise, m_rise);
      check("m_fall", swi_fall, m_fall);
      check("m_chg", {7'b0, swi_changed}, {7'b0, m_chg});
      check("m_tog", swi_toggle, m_tog);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  task automatic chk_zero(input string nm);
    check({nm, "_db"}, swi_db, 8'h00);
    check({nm, "_rise"}, swi_rise, 8'h00);
    check({nm, "_fall"}, swi_fall, 8'h00);
    check({nm, "_chg"}, {7'b0, swi_changed}, 8'h00);
    check({nm, "_tog"}, swi_toggle, 8'h00);
  endtask

  logic [NB-1:0] exp_tog;

  initial begin
    #1 reset_n = 1'b0;
    #1 chk_zero("rst0");
    cyc(2);
    #1 reset_n = 1'b1;
    chk_en = 1'b1;
    cyc(10);
    check("idle_db", swi_db, 8'h00);

    // clean change
    swi_raw = 8'h05;
    cyc(5);
    check("clean_early", swi_db, 8'h00);
    cyc(1);
    check("clean_db", swi_db, 8'h05);
    check("clean_rise", swi_rise, 8'h05);
    check("clean_fall", swi_fall, 8'h00);
    check("clean_chg", {7'b0, swi_changed}, 8'h01);
    cyc(1);
    check("clean_rise1", swi_rise, 8'h00);
    check("clean_chg1", {7'b0, swi_changed}, 8'h00);
    swi_raw = 8'h00;
    cyc(10);

    // bounce on bit 0
    swi_raw = 8'h01; cyc(1);
    swi_raw = 8'h00; cyc(1);
    swi_raw = 8'h01; cyc(1);
    swi_raw = 8'h00; cyc(1);
    swi_raw = 8'h01;
    cyc(5);
    check("bnc_early", swi_rise, 8'h00);
    cyc(1);
    check("bnc_rise", swi_rise, 8'h01);
    check("bnc_db", swi_db, 8'h01);
    swi_raw = 8'h00;
    cyc(10);

    // short glitch on bit 3
    swi_raw = 8'h08;
    cyc(3);
    swi_raw = 8'h00;
    cyc(10);
    check("glitch_db", swi_db, 8'h00);

    // mixed edges
    swi_raw = 8'hF0;
    cyc(10);
    check("mix_pre", swi_db, 8'hF0);
    swi_raw = 8'h0F;
    cyc(5);
    check("mix_early", swi_db, 8'hF0);
    cyc(1);
    check("mix_rise", swi_rise, 8'h0F);
    check("mix_fall", swi_fall, 8'hF0);
    check("mix_db", swi_db, 8'h0F);
    check("mix_chg", {7'b0, swi_changed}, 8'h01);

    // reset while pending
    swi_raw = 8'hF0;
    cyc(10);
    swi_raw = 8'h0F;
    cyc(3);
    #1 reset_n = 1'b0;
    #1 chk_zero("rstp");
    #1 reset_n = 1'b1;
    cyc(5);
    check("rstp_early", swi_rise, 8'h00);
    cyc(1);
    check("rstp_rise", swi_rise, 8'h0F);
    check("rstp_fall", swi_fall, 8'h00);
    check("rstp_db", swi_db, 8'h0F);

    // toggle presses on bit 1
    swi_raw = 8'h00;
    cyc(10);
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    cyc(2);
    for (int p = 0; p < 3; p++) begin
      swi_raw = 8'h02;
      cyc(10);
`ifdef SWITCH_TOGGLE_EN
      exp_tog = (p == 1) ? 8'h00 : 8'h02;
`else
      exp_tog = 8'h00;
`endif
      check("tog", swi_toggle, exp_tog);
      swi_raw = 8'h00;
      cyc(10);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
